sync_fifo_burst_reader: RTL

Read-side master for `sync_fifo`. It drains the FIFO master port (`o_valid_m`/`i_ready_m`/`o_dataout`) and re-emits the words as fixed-length bursts on a downstream valid/ready stream, marking the final beat with `o_last`. If data waits too long without a full burst accumulating, a timeout flush emits the partial contents as a short burst. It sits between `sync_fifo` and any packet-oriented consumer.

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_burst_reader_out_reg.sv | 31 +++
 rtl/sync_fifo_burst_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo family: default word width, burst reader
// state encoding and default burst/timeout settings.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package sync_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } burst_rd_state_e;

  localparam int unsigned BURST_RD_LEN_DEFAULT     = 4;
  localparam int unsigned BURST_RD_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/sync_fifo_burst_reader_out_reg.sv
// Downstream output register: loads a beat, holds it stable under backpressure,
// and drops valid once the beat is accepted with nothing new to load.
module burst_out_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_last  <= i_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sync_fifo_burst_reader.sv
// Drains a show-ahead sync_fifo and re-emits its words as fixed-length bursts,
// flushing a short burst when a partial load has waited TIMEOUT cycles.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sync_fifo_burst_reader
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned BURST_LEN  = BURST_RD_LEN_DEFAULT,
  parameter int unsigned TIMEOUT    = BURST_RD_TIMEOUT_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fifo_valid,
  input  logic                  i_fifo_almostempty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready
);

  localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BEAT_W  = $clog2(BURST_LEN);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_LEN - 1);

  burst_rd_state_e       r_state, w_state_nxt;
  logic [TIMER_W-1:0]    r_timer, w_timer_nxt;
  logic [BEAT_W-1:0]     r_beat_cnt, w_beat_nxt;
  logic [DATA_WIDTH-1:0] r_hold, w_hold_nxt;
  logic                  r_hold_vld, w_hold_vld_nxt;

  logic                  w_out_free;
  logic                  w_fifo_ready;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_load_last;

  assign w_out_free   = ~o_valid | i_ready;
  assign o_fifo_ready = w_fifo_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_beat_cnt <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_vld <= w_hold_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_beat_nxt     = r_beat_cnt;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;
    w_fifo_ready   = 1'b0;
    w_load         = 1'b0;
    w_load_data    = i_fifo_data;
    w_load_last    = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_fifo_valid && !i_fifo_almostempty) begin
          w_state_nxt = BURST;
          w_beat_nxt  = '0;
          w_timer_nxt = '0;
        end else if (i_fifo_valid) begin
          if (r_timer == TIMER_LAST) begin
            w_state_nxt = FLUSH;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end else begin
          w_timer_nxt = '0;
        end
      end

      BURST: begin
        w_fifo_ready = w_out_free;
        if (w_out_free && i_fifo_valid) begin
          w_load      = 1'b1;
          w_load_data = i_fifo_data;
          w_load_last = (r_beat_cnt == BEAT_LAST);
          if (r_beat_cnt == BEAT_LAST) begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat_cnt + 1'b1;
          end
        end
      end

      FLUSH: begin
        // The hold register lets us see whether another word follows before
        // committing o_last on the beat currently being presented.
        if (!r_hold_vld) begin
          w_fifo_ready = i_fifo_valid;
          if (i_fifo_valid) begin
            w_hold_nxt     = i_fifo_data;
            w_hold_vld_nxt = 1'b1;
          end
        end else if (w_out_free) begin
          w_load      = 1'b1;
          w_load_data = r_hold;
          if ((r_beat_cnt == BEAT_LAST) || !i_fifo_valid) begin
            w_load_last    = 1'b1;
            w_hold_vld_nxt = 1'b0;
            w_beat_nxt     = '0;
            w_state_nxt    = IDLE;
          end else begin
            w_load_last  = 1'b0;
            w_beat_nxt   = r_beat_cnt + 1'b1;
            w_fifo_ready = 1'b1;
            w_hold_nxt   = i_fifo_data;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  burst_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_last  (w_load_last),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last)
  );

endmodule
